// File: rtl/inv_sbox_in_gf16_seq_pkg.sv
// rtl/inv_sbox_in_gf16_seq_pkg.sv - shared constants, FSM encoding and GF(2^8) helpers for the InvSubBytes engine
// Contents: AES_STATE_W, INV_AFFINE_C, fsm_state_t, inv_affine(), gf_mul(), gf_sq()
package inv_sbox_in_gf16_seq_pkg;

    localparam int         AES_STATE_W  = 128;
    localparam logic [7:0] INV_AFFINE_C = 8'h05;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

    // b[i] = a[(i+2)%8] ^ a[(i+5)%8] ^ a[(i+7)%8] ^ c[i]
    function automatic logic [7:0] inv_affine(input logic [7:0] a);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = a[(i + 2) % 8] ^ a[(i + 5) % 8] ^ a[(i + 7) % 8] ^ INV_AFFINE_C[i];
        end
        return b;
    endfunction

    // Polynomial-basis multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_sq(input logic [7:0] a);
        return gf_mul(a, a);
    endfunction

endpackage

// File: rtl/inv_sbox_in_gf16_seq_byte.sv
// rtl/inv_sbox_in_gf16_seq_byte.sv - combinational per-byte inverse S-box (inverse affine, then GF(2^8) inverse)
// inversion_gf16: a[7:0] -> z[7:0], multiplicative inverse, 0 -> 0
// inv_sbox_byte:  a[7:0] -> z[7:0], inverse AES S-box
module inversion_gf16
    import inv_sbox_in_gf16_seq_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] z
);

    logic [7:0] x2, x4, x8, x16;
    logic [7:0] nrm, n2, n4, n8, nrm_inv;

    // The norm a^17 lies in the GF(2^4) subfield, so its inverse is n^14
    // (n^15 = 1 there). Then a^-1 = a^16 * (a^17)^-1. a=0 gives 0 naturally.
    always_comb begin
        x2      = gf_sq(a);
        x4      = gf_sq(x2);
        x8      = gf_sq(x4);
        x16     = gf_sq(x8);
        nrm     = gf_mul(x16, a);
        n2      = gf_sq(nrm);
        n4      = gf_sq(n2);
        n8      = gf_sq(n4);
        nrm_inv = gf_mul(gf_mul(n8, n4), n2);
        z       = gf_mul(x16, nrm_inv);
    end

endmodule

module inv_sbox_byte
    import inv_sbox_in_gf16_seq_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] z
);

    logic [7:0] y;

    assign y = inv_affine(a);

    inversion_gf16 u_inv (
        .a (y),
        .z (z)
    );

endmodule

// File: rtl/inv_sbox_in_gf16_seq.sv
// rtl/inv_sbox_in_gf16_seq.sv - sequential InvSubBytes engine, BPC bytes per cycle, valid/ready in and out
// Ports: clk, rst_n (async low), flush (sync abort),
//        in_valid/in_ready/in_state[127:0], out_valid/out_ready/out_state[127:0], busy
module inv_sbox_in_gf16_seq
    import inv_sbox_in_gf16_seq_pkg::*;
#(
    parameter int BPC = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    localparam int NBEATS = 16 / BPC;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int LANE_W = 8 * BPC;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

    if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
        $error("inv_sbox_in_gf16_seq: BPC must be 1, 2, 4, 8 or 16");
    end

    fsm_state_t             state;
    logic [CW-1:0]          cnt;
    logic [AES_STATE_W-1:0] work;
    logic [AES_STATE_W-1:0] result;
    logic [LANE_W-1:0]      lane_in;
    logic [LANE_W-1:0]      lane_out;
    int                     beat_base;

    assign beat_base = int'(cnt) * LANE_W;
    assign lane_in   = work[beat_base +: LANE_W];

    for (genvar g = 0; g < BPC; g++) begin : g_lane
        inv_sbox_byte u_byte (
            .a (lane_in[8*g +: 8]),
            .z (lane_out[8*g +: 8])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            work   <= '0;
            result <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        work  <= in_state;
                        cnt   <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    result[beat_base +: LANE_W] <= lane_out;
                    if (cnt == LAST_BEAT) begin
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // in_ready is gated by rst_n so it drops immediately while reset is held
    assign in_ready  = rst_n && (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign out_state = result;

endmodule

// File: tb/tb_inv_sbox_in_gf16_seq.sv
// tb/tb_inv_sbox_in_gf16_seq.sv - self-checking bench for inv_sbox_in_gf16_seq across BPC=4,1,2,8,16
module tb_inv_sbox_in_gf16_seq;

    localparam int NDUT = 5;
    localparam int NRT  = 250;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_state = '0;
    logic         in_valid_v  [NDUT];
    logic         in_ready_v  [NDUT];
    logic         out_valid_v [NDUT];
    logic [127:0] out_state_v [NDUT];
    logic         busy_v      [NDUT];

    int tests = 0;
    int fails = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    always #5 clk = ~clk;

    function automatic int bpc_of(input int k);
        case (k)
            0: return 4;
            1: return 1;
            2: return 2;
            3: return 8;
            default: return 16;
        endcase
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int P = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 8 : 16;
        inv_sbox_in_gf16_seq #(.BPC(P)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .in_state  (in_state),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready),
            .out_state (out_state_v[g]),
            .busy      (busy_v[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain modular arithmetic, inverse by exhaustive search, standard forward affine
    function automatic int gmul(input int a, input int b);
        int p = 0;
        int x = a;
        for (int i = 0; i < 8; i++) begin
            if (((b >> i) & 1) != 0) p = p ^ x;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11b;
        end
        return p;
    endfunction

    function automatic int rotl8(input int x, input int n);
        return ((x << n) | (x >> (8 - n))) & 'hff;
    endfunction

    task automatic build_tables();
        for (int a = 0; a < 256; a++) begin
            int inv = 0;
            int s;
            if (a != 0) begin
                for (int b = 1; b < 256; b++) begin
                    if (gmul(a, b) == 1) inv = b;
                end
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 'h63;
            fwd_tab[a] = 8'(s);
            inv_tab[s] = 8'(a);
        end
    endtask

    function automatic logic [127:0] fwd_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd_tab[s[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] inv_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[s[8*i +: 8]];
        return r;
    endfunction

    // Present st for one cycle; handshake happens at the next rising edge
    task automatic start(input int k, input logic [127:0] st);
        in_state      = st;
        in_valid_v[k] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[k] = 1'b0;
    endtask

    task automatic wait_out(input int k, output int lat);
        lat = 0;
        while (!out_valid_v[k] && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic send(input int k, input logic [127:0] st, output logic [127:0] got, output int lat);
        start(k, st);
        wait_out(k, lat);
        got = out_state_v[k];
        drain();
    endtask

    initial begin
        logic [127:0] got;
        logic [127:0] exp;
        logic [127:0] p;
        int lat;
        logic seen;

        for (int k = 0; k < NDUT; k++) in_valid_v[k] = 1'b0;
        build_tables();

        // Reset values
        #2 rst_n = 1'b0;
        #2;
        check("rst_in_ready", in_ready_v[0], 1'b0);
        check("rst_out_valid", out_valid_v[0], 1'b0);
        check("rst_out_state", out_state_v[0], 128'h0);
        check("rst_busy", busy_v[0], 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", in_ready_v[0], 1'b1);

        // Byte corners
        send(0, {16{8'h63}}, got, lat); check("corner_63", got, {16{8'h00}});
        send(0, {16{8'h7c}}, got, lat); check("corner_7c", got, {16{8'h01}});
        send(0, {16{8'h16}}, got, lat); check("corner_16", got, {16{8'hff}});
        send(0, {16{8'h00}}, got, lat); check("corner_00", got, {16{8'h52}});

        // Lane placement and latency
        send(0, {{14{8'h63}}, 8'hed, 8'h01}, got, lat);
        check("lanes", got, {{14{8'h00}}, 8'h53, 8'h09});
        check("lanes_latency", lat, 4);

        // Backpressure
        start(0, {16{8'h16}});
        wait_out(0, lat);
        check("bp_latency", lat, 4);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", out_valid_v[0], 1'b1);
            check("bp_out_state", out_state_v[0], {16{8'hff}});
            check("bp_in_ready", in_ready_v[0], 1'b0);
            @(posedge clk); #1;
        end
        drain();
        check("bp_release_in_ready", in_ready_v[0], 1'b1);
        check("bp_release_out_valid", out_valid_v[0], 1'b0);

        // Randomized round trip through every BPC
        for (int k = 0; k < NDUT; k++) begin
            for (int n = 0; n < NRT; n++) begin
                p = {$urandom, $urandom, $urandom, $urandom};
                check("rt_in_ready", in_ready_v[k], 1'b1);
                send(k, fwd_state(p), got, lat);
                check($sformatf("rt_bpc%0d", bpc_of(k)), got, p);
                if (n < 4) check($sformatf("rt_lat_bpc%0d", bpc_of(k)), lat, 16 / bpc_of(k));
            end
        end

        // Flush in the 2nd BUSY cycle
        start(0, {16{8'h7c}});
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", busy_v[0], 1'b0);
        check("flush_in_ready", in_ready_v[0], 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid_v[0]) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("flush_no_out_valid", seen, 1'b0);

        // Flush coincident with handshake
        in_state      = {16{8'h00}};
        in_valid_v[0] = 1'b1;
        flush         = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        flush         = 1'b0;
        check("flush_hs_busy", busy_v[0], 1'b0);
        check("flush_hs_in_ready", in_ready_v[0], 1'b1);

        p = {$urandom, $urandom, $urandom, $urandom};
        send(0, p, got, lat);
        check("after_flush", got, inv_state(p));

        // Asynchronous reset mid-BUSY
        start(0, {16{8'h16}});
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready_v[0], 1'b0);
        check("arst_out_valid", out_valid_v[0], 1'b0);
        check("arst_out_state", out_state_v[0], 128'h0);
        check("arst_busy", busy_v[0], 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        p = {$urandom, $urandom, $urandom, $urandom};
        send(0, p, got, lat);
        check("after_arst", got, inv_state(p));
        check("after_arst_latency", lat, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
